// File: rtl/priority_arbiter_8_if.sv
// Request/grant bundle for priority_arbiter_8: requesters drive req (master),
// the arbiter drives the registered grant outputs (slave).
interface priority_arbiter_8_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (output req, input gnt, gnt_idx, gnt_valid, timeout);
  modport slave  (input req, output gnt, gnt_idx, gnt_valid, timeout);
endinterface

// File: rtl/priority_arbiter_8.sv
// 8-requester arbiter with registered one-hot grant, hold-until-release and an
// optional hold timeout. Define ROUND_ROBIN_EN for rotating priority.
module priority_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  priority_arbiter_8_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam bit         TO_EN     = (MAX_HOLD != 0);
  localparam logic [4:0] HOLD_LAST = TO_EN ? 5'(MAX_HOLD - 1) : 5'd0;

  state_t     state;
  logic [7:0] gnt_q;
  logic [2:0] idx_q;
  logic       valid_q;
  logic       timeout_q;
  logic [4:0] hold_q;
`ifdef ROUND_ROBIN_EN
  logic [2:0] rr_ptr;
`endif

  logic [7:0] others;
  logic [7:0] cand;
  logic [2:0] win;
  logic       do_grant;
  logic       do_idle;
  logic       to_fire;

`ifdef ROUND_ROBIN_EN
  // Scan ptr, ptr-7, ..., ptr-1; the last hit (ptr-1 side) has highest priority.
  function automatic logic [2:0] winner(input logic [7:0] m, input logic [2:0] ptr);
    logic [2:0] w;
    logic [2:0] i;
    w = '0;
    for (int unsigned k = 8; k >= 1; k--) begin
      i = ptr - 3'(k);
      if (m[i]) w = i;
    end
    return w;
  endfunction
`else
  function automatic logic [2:0] winner(input logic [7:0] m);
    logic [2:0] w;
    logic [2:0] i;
    w = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      i = 3'(k);
      if (m[i]) w = i;
    end
    return w;
  endfunction
`endif

  always_comb begin
    others   = bus.req & ~(8'd1 << idx_q);
    cand     = bus.req;
    do_grant = 1'b0;
    do_idle  = 1'b0;
    to_fire  = 1'b0;
    case (state)
      IDLE: do_grant = |bus.req;
      GRANT: begin
        // Release is tested first so it masks a coincident timeout.
        if (!bus.req[idx_q]) begin
          cand     = others;
          do_grant = |others;
          do_idle  = ~|others;
        end else if (TO_EN && hold_q == HOLD_LAST) begin
          to_fire  = 1'b1;
          cand     = others;
          do_grant = |others;
          do_idle  = ~|others;
        end
      end
      default: ;
    endcase
`ifdef ROUND_ROBIN_EN
    win = winner(cand, rr_ptr);
`else
    win = winner(cand);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
`ifdef ROUND_ROBIN_EN
      rr_ptr    <= '0;
`endif
    end else begin
      timeout_q <= to_fire;
      if (do_grant) begin
        state   <= GRANT;
        gnt_q   <= 8'd1 << win;
        idx_q   <= win;
        valid_q <= 1'b1;
        hold_q  <= '0;
`ifdef ROUND_ROBIN_EN
        rr_ptr  <= win;
`endif
      end else if (do_idle) begin
        state   <= IDLE;
        gnt_q   <= '0;
        idx_q   <= '0;
        valid_q <= 1'b0;
        hold_q  <= '0;
      end else if (state == GRANT && hold_q != '1) begin
        hold_q  <= hold_q + 5'd1;
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_priority_arbiter_8.sv
// Bench for priority_arbiter_8: three instances (MAX_HOLD 16, 4, 0) share one
// request stream and are checked every cycle against an owner/hold model.
module tb_priority_arbiter_8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;

  always #5 clk = ~clk;

  priority_arbiter_8_if if16 ();
  priority_arbiter_8_if if4 ();
  priority_arbiter_8_if if0 ();
  assign if16.req = req;
  assign if4.req  = req;
  assign if0.req  = req;

  priority_arbiter_8 #(.MAX_HOLD(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
  priority_arbiter_8 #(.MAX_HOLD(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  priority_arbiter_8 #(.MAX_HOLD(0))  dut0  (.clk(clk), .rst_n(rst_n), .bus(if0.slave));

  logic [7:0] a_gnt [3];
  logic [2:0] a_idx [3];
  logic       a_val [3];
  logic       a_to  [3];
  assign a_gnt[0] = if16.gnt; assign a_idx[0] = if16.gnt_idx;
  assign a_val[0] = if16.gnt_valid; assign a_to[0] = if16.timeout;
  assign a_gnt[1] = if4.gnt;  assign a_idx[1] = if4.gnt_idx;
  assign a_val[1] = if4.gnt_valid;  assign a_to[1] = if4.timeout;
  assign a_gnt[2] = if0.gnt;  assign a_idx[2] = if0.gnt_idx;
  assign a_val[2] = if0.gnt_valid;  assign a_to[2] = if0.timeout;

  int n_checks = 0;
  int n_err = 0;
  bit checking = 1'b0;

  // Model: owner (-1 = none), cycles held, last granted, timeout pulse.
  int m_hold_max [3] = '{16, 4, 0};
  int m_own [3] = '{-1, -1, -1};
  int m_hold [3] = '{0, 0, 0};
  int m_rr [3] = '{0, 0, 0};
  bit m_to [3] = '{1'b0, 1'b0, 1'b0};

  function automatic int pick(input logic [7:0] v, input int last);
`ifdef ROUND_ROBIN_EN
    for (int d = 1; d <= 8; d++)
      if (v[(last - d + 16) % 8]) return (last - d + 16) % 8;
`else
    for (int i = 7; i >= 0; i--)
      if (v[i]) return i;
`endif
    return -1;
  endfunction

  task automatic hand_over(input int k, input logic [7:0] r);
    logic [7:0] p;
    p = r;
    p[m_own[k]] = 1'b0;
    if (p != 0) begin
      m_own[k] = pick(p, m_rr[k]);
      m_rr[k] = m_own[k];
    end else begin
      m_own[k] = -1;
    end
    m_hold[k] = 0;
  endtask

  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_own[k] = -1; m_hold[k] = 0; m_rr[k] = 0; m_to[k] = 1'b0;
      end else begin
        m_to[k] = 1'b0;
        if (m_own[k] < 0) begin
          if (req != 0) begin
            m_own[k] = pick(req, m_rr[k]);
            m_rr[k] = m_own[k];
            m_hold[k] = 0;
          end
        end else if (!req[m_own[k]]) begin
          hand_over(k, req);
        end else if (m_hold_max[k] != 0 && m_hold[k] == m_hold_max[k] - 1) begin
          m_to[k] = 1'b1;
          hand_over(k, req);
        end else if (m_hold[k] < 31) begin
          m_hold[k]++;
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (checking) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("model_gnt[%0d]", k), int'(a_gnt[k]), (m_own[k] < 0) ? 0 : (1 << m_own[k]));
        chk($sformatf("model_idx[%0d]", k), int'(a_idx[k]), (m_own[k] < 0) ? 0 : m_own[k]);
        chk($sformatf("model_valid[%0d]", k), int'(a_val[k]), (m_own[k] < 0) ? 0 : 1);
        chk($sformatf("model_timeout[%0d]", k), int'(a_to[k]), int'(m_to[k]));
      end
    end
  end

  // Inputs change just after the falling edge; checks run 1 time unit later.
  task automatic step(input logic [7:0] r, input logic rn);
    req = r;
    rst_n = rn;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic pin16(input string nm, input int g, input int i, input int v, input int t);
    chk({nm, "_gnt"}, int'(if16.gnt), g);
    chk({nm, "_idx"}, int'(if16.gnt_idx), i);
    chk({nm, "_valid"}, int'(if16.gnt_valid), v);
    chk({nm, "_timeout"}, int'(if16.timeout), t);
  endtask

  initial begin
    int seq [10];
    logic [7:0] r;
    #1;
    step(8'h00, 1'b0);
    checking = 1'b1;
    step(8'h00, 1'b0);
    pin16("reset", 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(8'h00, 1'b1);
      pin16("idle", 0, 0, 0, 0);
    end

    step(8'b0001_0100, 1'b1);
    pin16("first", 8'b0001_0000, 4, 1, 0);
    step(8'b0000_0100, 1'b1);
    pin16("nobubble", 8'b0000_0100, 2, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(8'b1000_0100, 1'b1);
      pin16("nopreempt", 8'b0000_0100, 2, 1, 0);
    end
    step(8'b1000_0000, 1'b1);
    pin16("handover7", 8'b1000_0000, 7, 1, 0);
    step(8'h00, 1'b1);
    pin16("release_idle", 0, 0, 0, 0);

    step(8'b0000_1001, 1'b1);
    pin16("hold3", 8'b0000_1000, 3, 1, 0);
    for (int i = 1; i < 16; i++) step(8'b0000_1001, 1'b1);
    pin16("hold3_last", 8'b0000_1000, 3, 1, 0);
    step(8'b0000_1001, 1'b1);
    pin16("timeout_a", 8'b0000_0001, 0, 1, 1);
    step(8'b0000_1001, 1'b1);
    pin16("pulse_one_cycle", 8'b0000_0001, 0, 1, 0);
    for (int i = 2; i < 16; i++) step(8'b0000_1001, 1'b1);
    step(8'b0000_1001, 1'b1);
    pin16("timeout_b", 8'b0000_1000, 3, 1, 1);

    step(8'h00, 1'b1);
    step(8'b0010_0000, 1'b1);
    pin16("own5", 8'b0010_0000, 5, 1, 0);
    for (int i = 1; i < 16; i++) step(8'b0010_0000, 1'b1);
    step(8'b0000_0010, 1'b1);
    pin16("release_beats_timeout", 8'b0000_0010, 1, 1, 0);
    step(8'b0000_0010, 1'b1);
    step(8'b0000_0010, 1'b0);
    pin16("reset_midgrant", 0, 0, 0, 0);

    for (int h = 0; h < 10; h++) begin
`ifdef ROUND_ROBIN_EN
      seq[h] = (7 - h + 8) % 8;
`else
      seq[h] = (h % 2 == 0) ? 7 : 6;
`endif
    end
    for (int h = 0; h < 10; h++) begin
      step(8'hFF, 1'b1);
      chk($sformatf("seq4_idx[%0d]", h), int'(if4.gnt_idx), seq[h]);
      chk($sformatf("seq4_timeout[%0d]", h), int'(if4.timeout), (h > 0) ? 1 : 0);
      for (int c = 1; c < 4; c++) begin
        step(8'hFF, 1'b1);
        chk($sformatf("seq4_hold[%0d]", h), int'(if4.gnt_idx), seq[h]);
      end
    end

    r = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) r = 8'($urandom);
      else if ($urandom_range(0, 3) == 0) r[$urandom_range(0, 7)] = ~r[$urandom_range(0, 7)];
      step(r, ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1);
    end

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/priority_arbiter_8.md
Name: priority_arbiter_8

Overview:
- 8-requester bus/resource arbiter built around 8:3 priority encoding.
- Samples a request vector and issues a registered one-hot grant, a 3-bit grant index and a valid flag.
- Holds the grant until the owner drops its request, or until a hold-timeout expires.
- Sits in front of any shared resource (bus, memory port, UART TX) that several masters contend for.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles one owner may hold the grant. Legal range is 0 to 31. 0 disables the timeout.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst_n  input  1  reset; synchronous, active-low.
- req  input  8  request vector. req[i]=1 means requester i wants the resource.
- gnt  output  8  one-hot grant, registered. Either all-zero or exactly one bit set.
- gnt_idx  output  3  binary index of the granted requester. It is 0 when gnt_valid=0.
- gnt_valid  output  1  high while a grant is active. It equals |gnt.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked by the hold limit.

Behaviour:
- Reset: while rst_n=0 at a rising edge, all state clears:
  - gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0.
  - State goes to IDLE, hold_cnt=0, rr_ptr=3'd0.
- States: IDLE and GRANT. hold_cnt is 5 bits.
- Arbitration function: winner(mask_vec) is the highest-priority set bit of mask_vec.
  - Default priority is fixed: bit 7 is highest, bit 0 is lowest.
  - Result is undefined/unused when mask_vec is 0.
- IDLE:
  - If req != 0, at the next edge go to GRANT with gnt=onehot(winner(req)), gnt_idx=winner, gnt_valid=1, hold_cnt=0.
  - Otherwise stay in IDLE.
  - Latency: req sampled at edge N gives grant visible after edge N (one-cycle registered).
- GRANT, evaluated each edge. Let o = gnt_idx.
  - Release: req[o]=0.
    - Let p = req with bit o cleared.
    - If p != 0, grant winner(p) at this edge with no idle bubble and reset hold_cnt to 0.
    - Otherwise go to IDLE and clear gnt, gnt_idx and gnt_valid.
  - Timeout: req[o]=1, MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1.
    - Assert timeout=1 for exactly the next cycle.
    - Let p = req with bit o cleared. If p != 0, grant winner(p) and reset hold_cnt to 0.
    - If p == 0, go to IDLE with gnt cleared. The former owner may be re-granted from IDLE on the following edge.
  - Otherwise keep the grant unchanged and increment hold_cnt, saturating at 31.
- Release and timeout in the same cycle: release takes precedence and no timeout pulse is generated.
- Requests from non-owners never preempt the current owner, whatever their priority.
- gnt changes only at clock edges. No combinational path from req to any output.
- timeout is 0 in every cycle other than the single pulse cycle.
- Reset asserted mid-grant: all outputs clear at that edge. The next grant requires rst_n=1 and a fresh IDLE evaluation.
- Invariants:
  - gnt is always 0 or one-hot.
  - gnt_valid == (gnt != 0).
  - gnt == (gnt_valid << gnt_idx).

Optional Feature:
- Macro: ROUND_ROBIN_EN.
- When defined: an rr_ptr register updates to the new winner's index on every new grant.
  - Priority order for winner() is rr_ptr-1, rr_ptr-2, ..., rr_ptr, modulo 8.
  - The last-granted requester therefore becomes lowest priority.
  - With rr_ptr=0 after reset, the order is 7..0, identical to fixed priority.
- When not defined: rr_ptr is absent and winner() always uses fixed priority, 7 highest.
- All other behaviour is unchanged in both builds.

Test Plan:
- Reset then req=8'h00 for 5 cycles -> gnt=8'h00, gnt_idx=0, gnt_valid=0, timeout=0 throughout.
- req=8'b00010100 -> after one edge, gnt=8'b00010000, gnt_idx=3'd4, gnt_valid=1. Then drop req[4] (req=8'b00000100) -> at the next edge gnt=8'b00000100, gnt_idx=2, with no idle cycle between.
- Owner 2 holding and req rises to 8'b10000100 -> gnt stays 8'b00000100 (no preemption) until req[2] drops, then gnt=8'b10000000, gnt_idx=7.
- MAX_HOLD=16, req=8'b00001001 held constant -> gnt_idx=3 for 16 cycles. Then timeout=1 for one cycle while gnt=8'b00000001. After 16 more cycles timeout pulses again and gnt returns to 8'b00001000.
- Owner 5 drops req[5] in the same cycle hold_cnt==MAX_HOLD-1 -> timeout stays 0. Then reassert rst_n=0 mid-grant -> gnt=0 and gnt_valid=0 at that edge.
- ROUND_ROBIN_EN build, req=8'hFF held, MAX_HOLD=4 -> grant sequence 7,6,5,...,0,7 with one timeout pulse per handover. Fixed build, same stimulus -> sequence alternates 7,6,7,6.
